// File: rtl/timer_alarm.sv
// rtl/timer_alarm.sv - absolute-target alarm with optional periodic reload against a free-running timebase
module timer_alarm #(
    parameter int TW = 32,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [TW-1:0] i_timer,
    input  logic          i_timer_rst,
    input  logic          i_cfg_valid,
    output logic          o_cfg_ready,
    input  logic [TW-1:0] i_cfg_target,
    input  logic [TW-1:0] i_cfg_period,
    input  logic          i_cancel,
    output logic          o_armed,
    output logic          o_fire,
    output logic          o_late,
    output logic [CW-1:0] o_fire_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t        state_q;
    logic [TW-1:0] target_q;
    logic [TW-1:0] period_q;
    logic          fire_q;
    logic          late_q;
    logic [CW-1:0] count_q;

    logic [TW-1:0] diff;
    logic          match;
    logic [CW-1:0] count_d;
    logic [TW-1:0] target_d;

    // Wrap-safe compare: the target counts as reached while the timer sits in
    // the half of the range at or after it.
    assign diff     = i_timer - target_q;
    assign match    = ~diff[TW-1];
    assign count_d  = (count_q == {CW{1'b1}}) ? count_q : count_q + CW'(1);
    assign target_d = target_q + period_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            period_q <= '0;
            fire_q   <= 1'b0;
            late_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            fire_q <= 1'b0;
            late_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_cfg_valid) begin
                        target_q <= i_cfg_target;
                        period_q <= i_cfg_period;
                        count_q  <= '0;
                        state_q  <= ARMED;
                    end
                end
                ARMED: begin
                    if (i_timer_rst || i_cancel) begin
                        state_q <= IDLE;
                    end else if (match) begin
                        fire_q  <= 1'b1;
                        late_q  <= (diff != '0);
                        count_q <= count_d;
                        if (period_q != '0) begin
                            target_q <= target_d;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_armed      = (state_q == ARMED);
    assign o_cfg_ready  = (state_q == IDLE);
    assign o_fire       = fire_q;
    assign o_late       = late_q;
    assign o_fire_count = count_q;

endmodule

// File: tb/tb_timer_alarm.sv
// tb/tb_timer_alarm.sv - scoreboard bench for timer_alarm with randomized traffic and a reference model
module tb_timer_alarm;

    localparam int TW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [TW-1:0] timer;
    logic          timer_rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [TW-1:0] cfg_target;
    logic [TW-1:0] cfg_period;
    logic          cancel;
    logic          armed;
    logic          fire;
    logic          late;
    logic [CW-1:0] fire_count;

    timer_alarm #(.TW(TW), .CW(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_timer      (timer),
        .i_timer_rst  (timer_rst),
        .i_cfg_valid  (cfg_valid),
        .o_cfg_ready  (cfg_ready),
        .i_cfg_target (cfg_target),
        .i_cfg_period (cfg_period),
        .i_cancel     (cancel),
        .o_armed      (armed),
        .o_fire       (fire),
        .o_late       (late),
        .o_fire_count (fire_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          fire;
        logic          late;
        logic [CW-1:0] count;
        logic          armed;
        logic          ready;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: what the alarm is waiting for, in plain terms.
    bit            m_armed  = 1'b0;
    logic [TW-1:0] m_target = '0;
    logic [TW-1:0] m_period = '0;
    int            m_count  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One clock of stimulus: drive at the falling edge and predict the
    // outputs that the next rising edge must produce.
    task automatic cyc(input logic [TW-1:0] tmr, input bit v = 0,
                       input logic [TW-1:0] tg = '0, input logic [TW-1:0] pr = '0,
                       input bit cn = 0, input bit tr = 0, input bit rs = 0);
        exp_t          e;
        logic [TW-1:0] d;
        @(negedge clk);
        timer      = tmr;
        cfg_valid  = v;
        cfg_target = tg;
        cfg_period = pr;
        cancel     = cn;
        timer_rst  = tr;
        rst        = rs;
        e.fire = 1'b0;
        e.late = 1'b0;
        if (rs) begin
            m_armed  = 1'b0;
            m_target = '0;
            m_period = '0;
            m_count  = 0;
        end else if (m_armed) begin
            d = tmr - m_target;
            if (tr || cn) begin
                m_armed = 1'b0;
            end else if ($signed(d) >= 0) begin
                e.fire  = 1'b1;
                e.late  = (tmr != m_target);
                m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
                if (m_period == 0) m_armed = 1'b0;
                else               m_target = m_target + m_period;
            end
        end else if (v) begin
            m_target = tg;
            m_period = pr;
            m_count  = 0;
            m_armed  = 1'b1;
        end
        e.count = m_count[CW-1:0];
        e.armed = m_armed;
        e.ready = !m_armed;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("fire",       int'(fire),       int'(e.fire));
                chk("late",       int'(late),       int'(e.late));
                chk("fire_count", int'(fire_count), int'(e.count));
                chk("armed",      int'(armed),      int'(e.armed));
                chk("cfg_ready",  int'(cfg_ready),  int'(e.ready));
            end
        end
    end

    initial begin : stimulus
        logic [TW-1:0] t;
        int            fires_seen;
        rst = 1'b1; timer = '0; timer_rst = 1'b0; cfg_valid = 1'b0;
        cfg_target = '0; cfg_period = '0; cancel = 1'b0;

        cyc(0, .rs(1));
        cyc(0, .rs(1));

        // One-shot on time
        cyc(90, .v(1), .tg(100), .pr(0));
        for (int i = 91; i <= 110; i++) cyc(i);

        // Periodic reload, then cancel to leave ARMED
        cyc(0, .v(1), .tg(50), .pr(10));
        for (int i = 1; i <= 85; i++) cyc(i);
        cyc(86, .cn(1));

        // Target beyond the wrap point must not fire early
        cyc(32'hFFFF_FFF0, .v(1), .tg(5), .pr(0));
        t = 32'hFFFF_FFF1;
        for (int i = 0; i < 32; i++) begin
            cyc(t);
            t = t + 1;
        end

        // Late arming, one-shot and periodic catch-up
        cyc(200, .v(1), .tg(150), .pr(0));
        cyc(200); cyc(200);
        cyc(200, .v(1), .tg(150), .pr(20));
        for (int i = 0; i < 6; i++) cyc(200);
        cyc(200, .cn(1));

        // Cancel coincident with match, then timer reset while armed
        cyc(0, .v(1), .tg(10), .pr(0));
        for (int i = 1; i <= 9; i++) cyc(i);
        cyc(10, .cn(1));
        cyc(11);
        cyc(11, .v(1), .tg(20), .pr(5));
        for (int i = 12; i <= 27; i++) cyc(i);
        cyc(0, .tr(1));
        cyc(1); cyc(2);

        // Reset while armed with three fires counted
        cyc(100, .v(1), .tg(0), .pr(1));
        cyc(100); cyc(100); cyc(100);
        cyc(100, .rs(1));
        cyc(100);

        // Counter saturation
        cyc(1000, .v(1), .tg(0), .pr(1));
        for (int i = 0; i < 24; i++) cyc(1000);
        cyc(1000, .cn(1));

        // Randomized traffic
        t = 0;
        fires_seen = 0;
        for (int i = 0; i < 600; i++) begin
            bit            rs, tr, cn, v;
            logic [TW-1:0] tg, pr;
            rs = ($urandom_range(0, 99) < 2);
            tr = ($urandom_range(0, 99) < 4);
            cn = ($urandom_range(0, 99) < 6);
            v  = ($urandom_range(0, 99) < 40);
            t  = tr ? '0 : t + $urandom_range(0, 3);
            tg = ($urandom_range(0, 3) == 0) ? t - $urandom_range(0, 30) : t + $urandom_range(0, 40);
            pr = ($urandom_range(0, 9) < 3) ? '0 : TW'($urandom_range(1, 15));
            cyc(t, v, tg, pr, cn, tr, rs);
            if (fire) fires_seen++;
        end
        cyc(t, .rs(1));

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
